// File: rtl/pipelined_core.sv
// Three-stage (fetch / execute / write-back) core with branch flush, stall and halt.
// Define PROC_FORWARD_EN to forward the write-back result into execute operands.
module pipelined_core #(
  parameter  int DATA_W  = 16,
  parameter  int REG_AW  = 4,
  parameter  int PC_W    = 8,
  localparam int INSTR_W = 5 + 3*REG_AW
) (
  input  logic               in_clk,
  input  logic               in_rst,
  output logic [PC_W-1:0]    out_imem_addr,
  input  logic [INSTR_W-1:0] in_imem_data,
  input  logic               in_stall,
  input  logic [REG_AW-1:0]  in_dbg_addr,
  output logic [DATA_W-1:0]  out_dbg_data,
  output logic               out_wb_en,
  output logic [REG_AW-1:0]  out_wb_addr,
  output logic [DATA_W-1:0]  out_wb_data,
  output logic               out_halted
);
  localparam int NREG = 1 << REG_AW;

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_LDI  = 5'd5;
  localparam logic [4:0] OP_BEQZ = 5'd6;
  localparam logic [4:0] OP_HALT = 5'd7;

  localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;
  logic               wb_en_reg, wb_en_next;
  logic [REG_AW-1:0]  wb_addr_reg, wb_addr_next;
  logic [DATA_W-1:0]  wb_data_reg, wb_data_next;
  logic               halted_reg, halted_next;
  logic [DATA_W-1:0]  regs [NREG];

  logic [4:0]          opcode;
  logic [REG_AW-1:0]   dest, src1, src2;
  logic [2*REG_AW-1:0] imm;
  logic [DATA_W-1:0]   op_a, op_b, ex_result;
  logic                ex_wr_en;

  assign opcode = ir_reg[INSTR_W-1 -: 5];
  assign dest   = ir_reg[3*REG_AW-1 -: REG_AW];
  assign src1   = ir_reg[2*REG_AW-1 -: REG_AW];
  assign src2   = ir_reg[REG_AW-1:0];
  assign imm    = ir_reg[2*REG_AW-1:0];

`ifdef PROC_FORWARD_EN
  assign op_a = (wb_en_reg && wb_addr_reg == src1) ? wb_data_reg : regs[src1];
  assign op_b = (wb_en_reg && wb_addr_reg == src2) ? wb_data_reg : regs[src2];
`else
  // Without forwarding a distance-1 consumer sees the pre-write-back value.
  assign op_a = regs[src1];
  assign op_b = regs[src2];
`endif

  always_comb begin
    ex_result = '0;
    ex_wr_en  = 1'b0;
    case (opcode)
      OP_ADD: begin ex_result = op_a + op_b;     ex_wr_en = 1'b1; end
      OP_SUB: begin ex_result = op_a - op_b;     ex_wr_en = 1'b1; end
      OP_AND: begin ex_result = op_a & op_b;     ex_wr_en = 1'b1; end
      OP_OR:  begin ex_result = op_a | op_b;     ex_wr_en = 1'b1; end
      OP_LDI: begin ex_result = DATA_W'(imm);    ex_wr_en = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    wb_en_next   = 1'b0;
    wb_addr_next = wb_addr_reg;
    wb_data_next = wb_data_reg;
    halted_next  = halted_reg;
    if (!in_stall) begin
      if (halted_reg) begin
        ir_next = INSTR_NOP;
      end else begin
        wb_en_next   = ex_wr_en;
        wb_addr_next = dest;
        wb_data_next = ex_result;
        if (opcode == OP_HALT) begin
          halted_next = 1'b1;
          ir_next     = INSTR_NOP;
        end else if (opcode == OP_BEQZ && op_a == '0) begin
          // Taken branch squashes the single wrong-path instruction in IR.
          pc_next = imm[PC_W-1:0];
          ir_next = INSTR_NOP;
        end else begin
          pc_next = pc_reg + PC_W'(1);
          ir_next = in_imem_data;
        end
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      pc_reg      <= '0;
      ir_reg      <= INSTR_NOP;
      wb_en_reg   <= 1'b0;
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
      halted_reg  <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      wb_en_reg   <= wb_en_next;
      wb_addr_reg <= wb_addr_next;
      wb_data_reg <= wb_data_next;
      halted_reg  <= halted_next;
    end
  end

  // Write-back commits regardless of stall; EX above already read the old value.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en_reg) begin
      regs[wb_addr_reg] <= wb_data_reg;
    end
  end

  assign out_imem_addr = pc_reg;
  assign out_dbg_data  = regs[in_dbg_addr];
  assign out_wb_en     = wb_en_reg;
  assign out_wb_addr   = wb_addr_reg;
  assign out_wb_data   = wb_data_reg;
  assign out_halted    = halted_reg;

endmodule

// File: tb/tb_pipelined_core.sv
// Bench for pipelined_core: ISA-level reference model compared every cycle,
// plus directed programs with hand-computed expectations.
`timescale 1ns/1ps
module tb_pipelined_core;
  logic        in_clk = 1'b0;
  logic        in_rst;
  logic [7:0]  out_imem_addr;
  logic [16:0] in_imem_data;
  logic        in_stall;
  logic [3:0]  in_dbg_addr;
  logic [15:0] out_dbg_data;
  logic        out_wb_en;
  logic [3:0]  out_wb_addr;
  logic [15:0] out_wb_data;
  logic        out_halted;

  pipelined_core dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .out_imem_addr(out_imem_addr), .in_imem_data(in_imem_data),
    .in_stall(in_stall), .in_dbg_addr(in_dbg_addr), .out_dbg_data(out_dbg_data),
    .out_wb_en(out_wb_en), .out_wb_addr(out_wb_addr), .out_wb_data(out_wb_data),
    .out_halted(out_halted)
  );

  always #5 in_clk = ~in_clk;

  logic [16:0] prog [256];
  assign in_imem_data = prog[out_imem_addr];

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] enc(input int op, input int d, input int s1, input int s2);
    return {5'(op), 4'(d), 4'(s1), 4'(s2)};
  endfunction

  // Reference model: architectural registers plus the fetched-but-not-executed
  // instruction and the pending write-back record.
  logic [7:0]  m_pc;
  logic [16:0] m_ir;
  logic        m_wb_en, m_halted;
  logic [3:0]  m_wb_addr;
  logic [15:0] m_wb_data;
  logic [15:0] m_regs [16];

  task automatic model_step();
    logic [4:0]  op;
    logic [3:0]  d, s1, s2;
    logic [15:0] a, b, res;
    if (!in_rst) begin
      m_pc = 0; m_ir = 0; m_wb_en = 0; m_wb_addr = 0; m_wb_data = 0; m_halted = 0;
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      return;
    end
    {op, d, s1, s2} = m_ir;
    a = m_regs[s1];
    b = m_regs[s2];
`ifdef PROC_FORWARD_EN
    if (m_wb_en && m_wb_addr == s1) a = m_wb_data;
    if (m_wb_en && m_wb_addr == s2) b = m_wb_data;
`endif
    if (m_wb_en) m_regs[m_wb_addr] = m_wb_data;
    if (in_stall) begin
      m_wb_en = 0;
    end else if (m_halted) begin
      m_wb_en = 0;
      m_ir = 0;
    end else begin
      case (op)
        1: res = a + b;
        2: res = a - b;
        3: res = a & b;
        4: res = a | b;
        5: res = {8'h00, s1, s2};
        default: res = 0;
      endcase
      m_wb_en = (op >= 1 && op <= 5);
      m_wb_addr = d;
      m_wb_data = res;
      if (op == 7) begin
        m_halted = 1; m_ir = 0;
      end else if (op == 6 && a == 0) begin
        m_pc = {s1, s2}; m_ir = 0;
      end else begin
        m_ir = prog[m_pc]; m_pc = m_pc + 1;
      end
    end
  endtask

  initial forever begin
    @(posedge in_clk);
    model_step();
  end

  initial forever begin
    @(negedge in_clk);
    if (cmp_en) begin
      check("imem_addr", 32'(out_imem_addr), 32'(m_pc));
      check("halted", 32'(out_halted), 32'(m_halted));
      check("wb_en", 32'(out_wb_en), 32'(m_wb_en));
      if (m_wb_en) begin
        check("wb_addr", 32'(out_wb_addr), 32'(m_wb_addr));
        check("wb_data", 32'(out_wb_data), 32'(m_wb_data));
      end
      check("dbg_data", 32'(out_dbg_data), 32'(m_regs[in_dbg_addr]));
    end
  end

  task automatic tick();
    @(posedge in_clk);
    #2;
    in_dbg_addr = in_dbg_addr + 4'd1;
  endtask

  task automatic rd(input logic [3:0] addr, output logic [15:0] data);
    in_dbg_addr = addr;
    #0.1;
    data = out_dbg_data;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = '0;
  endtask

  task automatic load_add();
    clear_prog();
    prog[0] = enc(5, 1, 1, 2);   // LDI r1,0x12
    prog[1] = enc(5, 2, 0, 5);   // LDI r2,0x05
    prog[2] = enc(1, 3, 1, 2);   // ADD r3,r1,r2
  endtask

  task automatic reset_core();
    in_rst = 1'b0;
    tick();
    tick();
    in_rst = 1'b1;
  endtask

  logic [15:0] v;
  logic [15:0] exp_add;
  int bad;

  initial begin
`ifdef PROC_FORWARD_EN
    exp_add = 16'h0017;
`else
    exp_add = 16'h0012;
`endif
    in_rst = 1'b0; in_stall = 1'b0; in_dbg_addr = '0;
    load_add();
    tick(); tick();
    cmp_en = 1'b1;

    // Reset asserted mid-program for three edges
    in_rst = 1'b1;
    repeat (4) tick();
    in_rst = 1'b0;
    repeat (3) tick();
    check("rst_addr", 32'(out_imem_addr), 32'h0);
    check("rst_halted", 32'(out_halted), 32'h0);
    check("rst_wb_en", 32'(out_wb_en), 32'h0);
    check("rst_wb_addr", 32'(out_wb_addr), 32'h0);
    check("rst_wb_data", 32'(out_wb_data), 32'h0);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      check("rst_dbg", 32'(v), 32'h0);
    end
    in_rst = 1'b1;
    repeat (8) tick();
    rd(4'd1, v); check("add_r1", 32'(v), 32'h0012);
    rd(4'd2, v); check("add_r2", 32'(v), 32'h0005);
    rd(4'd3, v); check("add_r3", 32'(v), 32'(exp_add));

    // Same program with a two-cycle stall while LDI r2 sits in IR
    reset_core();
    tick(); tick();
    check("stall_pre_addr", 32'(out_imem_addr), 32'h2);
    in_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_addr", 32'(out_imem_addr), 32'h2);
      check("stall_wb_en", 32'(out_wb_en), 32'h0);
    end
    in_stall = 1'b0;
    repeat (6) tick();
    rd(4'd3, v); check("stall_r3", 32'(v), 32'(exp_add));

    // SUB wraps modulo 2^16
    clear_prog();
    prog[0] = enc(5, 1, 0, 0);   // LDI r1,0
    prog[1] = enc(5, 2, 0, 1);   // LDI r2,1
    prog[4] = enc(2, 3, 1, 2);   // SUB r3,r1,r2
    reset_core();
    repeat (6) tick();
    check("sub_wb_en", 32'(out_wb_en), 32'h1);
    check("sub_wb_addr", 32'(out_wb_addr), 32'h3);
    check("sub_wb_data", 32'(out_wb_data), 32'hFFFF);
    repeat (2) tick();
    rd(4'd3, v); check("sub_r3", 32'(v), 32'hFFFF);

    // Taken branch flushes the following LDI r5
    clear_prog();
    prog[2] = enc(6, 0, 1, 0);   // BEQZ (s1=r1, zero after reset), target 0x10
    prog[3] = enc(5, 5, 0, 3);   // LDI r5,3 (wrong path)
    reset_core();
    bad = 0;
    repeat (3) tick();
    check("br_addr_3", 32'(out_imem_addr), 32'h03);
    tick();
    check("br_addr_10", 32'(out_imem_addr), 32'h10);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_wb_en && out_wb_addr == 4'd5) bad++;
    end
    check("br_no_r5_wb", 32'(bad), 32'h0);
    rd(4'd5, v); check("br_r5", 32'(v), 32'h0);

    // HALT stops the core; older LDI completes, younger LDI never does
    clear_prog();
    prog[0] = enc(5, 4, 0, 7);   // LDI r4,7
    prog[1] = enc(7, 0, 0, 0);   // HALT
    prog[2] = enc(5, 6, 0, 9);   // LDI r6,9
    reset_core();
    tick(); tick();
    check("halt_pre", 32'(out_halted), 32'h0);
    tick();
    check("halt_set", 32'(out_halted), 32'h1);
    check("halt_addr", 32'(out_imem_addr), 32'h2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_hold", 32'(out_halted), 32'h1);
      check("halt_addr_hold", 32'(out_imem_addr), 32'h2);
    end
    rd(4'd4, v); check("halt_r4", 32'(v), 32'h0007);
    rd(4'd6, v); check("halt_r6", 32'(v), 32'h0000);

    // Reset clears halt
    reset_core();
    tick();
    check("halt_cleared", 32'(out_halted), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
